rtc_bus_sequencer: RTL and testbench

// Sequences one complete access to the external RTC's multiplexed address/data
// bus on behalf of the PicoBlaze. Every access is an address phase, then a data phase.

---
 rtl/rtc_bus_sequencer.sv | 111 +++++++++++
 tb/tb_rtc_bus_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/rtc_bus_sequencer.sv
// rtc_bus_sequencer: runs one address-phase + data-phase access on the RTC multiplexed AD bus
module rtc_bus_sequencer #(
   parameter int T_PHASE = 4,
   parameter int T_GAP   = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req_wr,
   input  logic       req_rd,
   input  logic [7:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       busy,
   output logic       done,
   output logic [7:0] rd_data,
   output logic       rtc_cs_n,
   output logic       rtc_a_d,
   output logic       rtc_wr_n,
   output logic       rtc_rd_n,
   output logic [7:0] rtc_bus_out,
   output logic       rtc_bus_oe,
   input  logic [7:0] rtc_bus_in
);
   localparam int T_MAX = (T_PHASE > T_GAP) ? T_PHASE : T_GAP;
   localparam int CW = $clog2(T_MAX + 1);
   localparam logic [CW-1:0] GAP_LD = CW'(T_GAP - 1);
   localparam logic [CW-1:0] PH_LD = CW'(T_PHASE - 1);
   typedef enum logic [2:0] {IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, FIN} state_t;
   state_t state;
   logic [CW-1:0] cnt;
   logic is_wr;
   logic [7:0] wdata;
   logic last;
   assign last = (cnt == '0);
   // Outputs are set on the edge entering each state, so they are valid for its whole duration
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt <= '0;
         is_wr <= 1'b0;
         wdata <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         rd_data <= '0;
         rtc_cs_n <= 1'b1;
         rtc_a_d <= 1'b1;
         rtc_wr_n <= 1'b1;
         rtc_rd_n <= 1'b1;
         rtc_bus_out <= '0;
         rtc_bus_oe <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state != IDLE && !last) cnt <= cnt - CW'(1);
         case (state)
            IDLE: if (req_wr || req_rd) begin
               state <= A_SET;
               cnt <= GAP_LD;
               is_wr <= req_wr;
               wdata <= req_wdata;
               busy <= 1'b1;
               rtc_cs_n <= 1'b0;
               rtc_a_d <= 1'b0;
               rtc_bus_oe <= 1'b1;
               rtc_bus_out <= req_addr;
            end
            A_SET: if (last) begin
               state <= A_STB;
               cnt <= PH_LD;
               rtc_wr_n <= 1'b0;
            end
            A_STB: if (last) begin
               state <= A_HLD;
               cnt <= GAP_LD;
               rtc_wr_n <= 1'b1;
            end
            A_HLD: if (last) begin
               state <= D_SET;
               cnt <= GAP_LD;
               rtc_a_d <= 1'b1;
               rtc_bus_oe <= is_wr;
               rtc_bus_out <= is_wr ? wdata : 8'h00;
            end
            D_SET: if (last) begin
               state <= D_STB;
               cnt <= PH_LD;
               rtc_wr_n <= !is_wr;
               rtc_rd_n <= is_wr;
            end
            D_STB: if (last) begin
               state <= D_HLD;
               cnt <= GAP_LD;
               rtc_wr_n <= 1'b1;
               rtc_rd_n <= 1'b1;
               if (!is_wr) rd_data <= rtc_bus_in;
            end
            D_HLD: if (last) begin
               state <= FIN;
               cnt <= '0;
               done <= 1'b1;
               rtc_cs_n <= 1'b1;
               rtc_bus_oe <= 1'b0;
               rtc_bus_out <= 8'h00;
            end
            FIN: begin
               state <= IDLE;
               cnt <= '0;
               busy <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// tb_rtc_bus_sequencer: directed vector bench for the RTC bus sequencer (default and 1/1 timing)
module tb_rtc_bus_sequencer;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic req_wr = 1'b0, req_rd = 1'b0;
   logic [7:0] req_addr = '0, req_wdata = '0;
   logic busy, done, cs_n, a_d, wr_n, rd_n, bus_oe;
   logic [7:0] rd_data, bus_out, bus_in;
   logic [7:0] cur_rval = '0;
   logic f_req_wr = 1'b0;
   logic [7:0] f_req_addr = '0, f_req_wdata = '0;
   logic f_busy, f_done, f_cs_n, f_a_d, f_wr_n, f_rd_n, f_bus_oe;
   logic [7:0] f_rd_data, f_bus_out;
   logic [21:0] outs;
   int checks = 0, passes = 0, viol = 0;
   logic p_low = 1'b0, p_ad = 1'b1;
   localparam logic [21:0] RST_OUT = {1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0};

   always #5 clk = ~clk;
   assign bus_in = !rd_n ? cur_rval : 8'h00;
   assign outs = {busy, done, rd_data, cs_n, a_d, wr_n, rd_n, bus_out, bus_oe};

   rtc_bus_sequencer dut (
      .clk(clk), .reset_n(reset_n), .req_wr(req_wr), .req_rd(req_rd),
      .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy), .done(done),
      .rd_data(rd_data), .rtc_cs_n(cs_n), .rtc_a_d(a_d), .rtc_wr_n(wr_n),
      .rtc_rd_n(rd_n), .rtc_bus_out(bus_out), .rtc_bus_oe(bus_oe), .rtc_bus_in(bus_in)
   );

   rtc_bus_sequencer #(.T_PHASE(1), .T_GAP(1)) fast (
      .clk(clk), .reset_n(reset_n), .req_wr(f_req_wr), .req_rd(1'b0),
      .req_addr(f_req_addr), .req_wdata(f_req_wdata), .busy(f_busy), .done(f_done),
      .rd_data(f_rd_data), .rtc_cs_n(f_cs_n), .rtc_a_d(f_a_d), .rtc_wr_n(f_wr_n),
      .rtc_rd_n(f_rd_n), .rtc_bus_out(f_bus_out), .rtc_bus_oe(f_bus_oe), .rtc_bus_in(bus_in)
   );

   // Sequence invariants: no double strobe, no drive during read, a_d stable under a strobe
   always @(negedge clk) begin
      if (reset_n) begin
         if ((!wr_n && !rd_n) || (!rd_n && bus_oe) || ((!wr_n || !rd_n) && p_low && a_d != p_ad)) viol++;
         if ((!f_wr_n && !f_rd_n) || (!f_rd_n && f_bus_oe)) viol++;
         p_low = !wr_n || !rd_n;
         p_ad = a_d;
      end else p_low = 1'b0;
   end

   typedef struct {
      logic wr, rd, mid_rd;
      logic [7:0] addr, wdata, rval;
      int exp_dw, exp_dr;
      logic [7:0] exp_rdd;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int a_c = 0, dw = 0, dr = 0, bc = 0, dc = 0, dcyc = 0;
      logic [7:0] rdd = 8'hxx;
      cur_rval = v.rval;
      @(posedge clk); #1;
      req_wr = v.wr; req_rd = v.rd; req_addr = v.addr; req_wdata = v.wdata;
      @(posedge clk); #1;
      req_wr = 1'b0; req_rd = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (busy) bc++;
         if (!wr_n && !a_d && bus_oe && !cs_n && bus_out == v.addr) a_c++;
         if (!wr_n && a_d && bus_oe && !cs_n && bus_out == v.wdata) dw++;
         if (!rd_n && a_d && !bus_oe && !cs_n) dr++;
         if (done) begin dc++; dcyc = i; rdd = rd_data; end
         if (v.mid_rd) req_rd = (i == 5);
      end
      check({tag, " done_cycle"}, dcyc, 17);
      check({tag, " done_count"}, dc, 1);
      check({tag, " busy_cycles"}, bc, 17);
      check({tag, " addr_strobe"}, a_c, 4);
      check({tag, " data_wr_strobe"}, dw, v.exp_dw);
      check({tag, " data_rd_strobe"}, dr, v.exp_dr);
      check({tag, " rd_data"}, rdd, v.exp_rdd);
   endtask

   task automatic reset_mid(input logic data_phase, input string tag);
      int dc = 0;
      logic found = 1'b0;
      @(posedge clk); #1;
      req_wr = 1'b1; req_addr = 8'h44; req_wdata = 8'h55;
      @(posedge clk); #1;
      req_wr = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (!wr_n && a_d == data_phase) found = 1'b1;
      end
      check({tag, " strobe_reached"}, found, 1);
      #2 reset_n = 1'b0;
      #1 check({tag, " async_reset"}, outs, RST_OUT);
      @(negedge clk); @(negedge clk);
      reset_n = 1'b1;
      repeat (25) begin
         @(negedge clk);
         if (done) dc++;
      end
      check({tag, " no_done"}, dc, 0);
      check({tag, " idle_after"}, outs, RST_OUT);
   endtask

   initial begin
      vec_t vecs[5];
      vec_t post;
      int fb = 0, fw = 0, fdc = 0, d1 = 0, d2 = 0, run = 0, maxrun = 0;
      vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h21, 8'h59, 8'h00, 4, 0, 8'h00};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h22, 8'h00, 8'hA5, 0, 4, 8'hA5};
      vecs[2] = '{1'b1, 1'b1, 1'b1, 8'h30, 8'h77, 8'h99, 4, 0, 8'hA5};
      vecs[3] = '{1'b0, 1'b1, 1'b0, 8'h7F, 8'h00, 8'h3C, 0, 4, 8'h3C};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h00, 4, 0, 8'h3C};
      post    = '{1'b0, 1'b1, 1'b0, 8'h5A, 8'h00, 8'hC3, 0, 4, 8'hC3};
      repeat (3) @(negedge clk);
      check("reset_outputs", outs, RST_OUT);
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("idle_hold_%0d", i), outs, RST_OUT);
      end
      for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
      reset_mid(1'b0, "rst_a_stb");
      reset_mid(1'b1, "rst_d_stb");
      run_vec(post, "post_reset_rd");
      @(posedge clk); #1;
      f_req_wr = 1'b1; f_req_addr = 8'h11; f_req_wdata = 8'h22;
      @(posedge clk); #1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (i == 15) f_req_wr = 1'b0;
         if (f_busy) fb++;
         if (!f_wr_n) begin fw++; run++; end else run = 0;
         if (run > maxrun) maxrun = run;
         if (f_done) begin
            fdc++;
            if (fdc == 1) d1 = i; else d2 = i;
         end
      end
      check("fast first_done", d1, 7);
      check("fast second_done", d2, 15);
      check("fast done_count", fdc, 2);
      check("fast busy_cycles", fb, 14);
      check("fast wr_low_cycles", fw, 4);
      check("fast strobe_width", maxrun, 1);
      check("invariant_violations", viol, 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
